// File: rtl/btn_event_arb.sv
// btn_event_arb: shared-tick debounce for NUM_BTN buttons, round-robin dispatch into one valid/ready event stream.
// Long-press detection is compiled in only when LONG_PRESS_EN is defined.
module btn_event_arb #(
   parameter int          NUM_BTN    = 4,
   parameter int          ID_W       = 2,
   parameter logic [19:0] TICK_MAX   = 20'd1000000,
   parameter logic [7:0]  LONG_TICKS = 8'd100
) (
   input  logic               clock,
   input  logic               n_reset,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [ID_W-1:0]    evt_id,
   output logic               evt_long,
   output logic               evt_overrun,
   output logic [NUM_BTN-1:0] pending
);

   // state      | meaning
   // ST_IDLE    | nothing presented; pick the next requester round-robin
   // ST_PRESENT | evt_valid high; evt_id/evt_long frozen until evt_ready
   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_PRESENT = 1'b1;
   localparam int         IDX_W      = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

   logic [19:0]        r_cnt;
   logic               w_tick;
   logic [NUM_BTN-1:0] r_sync1;
   logic [NUM_BTN-1:0] r_sync2;
   logic [NUM_BTN-1:0] r_stable;
   logic [NUM_BTN-1:0] w_press;
   logic [NUM_BTN-1:0] r_pending;
   logic [NUM_BTN-1:0] w_clr_s;
   logic [NUM_BTN-1:0] w_req;
   logic [NUM_BTN-1:0] w_gvec;
   logic [0:0]         r_state;
   logic               r_evt_valid;
   logic [ID_W-1:0]    r_evt_id;
   logic [ID_W-1:0]    r_last_grant;
   logic               r_evt_overrun;
   logic               w_accept;
   logic               w_ovr;
   logic               w_found;
   logic [ID_W-1:0]    w_sel_id;

   assign w_tick = (r_cnt == TICK_MAX);

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         r_cnt <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 20'd1;
      end
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_stable <= '0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
         if (w_tick) begin
            r_stable <= r_sync2;
         end
      end
   end

   assign w_press  = r_sync2 & ~r_stable & {NUM_BTN{w_tick}};
   assign w_accept = (r_state == ST_PRESENT) & evt_ready;
   assign w_gvec   = NUM_BTN'(1) << r_evt_id;

`ifdef LONG_PRESS_EN
   logic [NUM_BTN-1:0] r_lpending;
   logic [NUM_BTN-1:0] w_lpress;
   logic [NUM_BTN-1:0] w_clr_l;
   logic [NUM_BTN-1:0] w_sel_vec;
   logic               r_evt_long;

   // Hold counter saturates at LONG_TICKS so each hold yields one long event.
   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_hold
      logic [7:0] r_hold;
      always_ff @(posedge clock or negedge n_reset) begin
         if (!n_reset) begin
            r_hold <= '0;
         end else if (!r_stable[gi]) begin
            r_hold <= '0;
         end else if (w_tick && (r_hold != LONG_TICKS)) begin
            r_hold <= r_hold + 8'd1;
         end
      end
      assign w_lpress[gi] = w_tick & r_stable[gi] & (r_hold != LONG_TICKS)
                            & ((r_hold + 8'd1) == LONG_TICKS);
   end

   assign w_req     = r_pending | r_lpending;
   assign w_clr_s   = (w_accept & ~r_evt_long) ? w_gvec : '0;
   assign w_clr_l   = (w_accept &  r_evt_long) ? w_gvec : '0;
   assign w_ovr     = (|(w_press & r_pending & ~w_clr_s)) | (|(w_lpress & r_lpending & ~w_clr_l));
   assign w_sel_vec = NUM_BTN'(1) << w_sel_id;

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         r_lpending <= '0;
      end else begin
         r_lpending <= (r_lpending & ~w_clr_l) | w_lpress;
      end
   end

   // Short press is served before the long press of the same button.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         r_evt_long <= 1'b0;
      end else if ((r_state == ST_IDLE) && w_found) begin
         r_evt_long <= ~|(r_pending & w_sel_vec);
      end
   end

   assign evt_long = r_evt_long;
`else
   logic w_unused_lt;

   assign w_unused_lt = ^LONG_TICKS;
   assign w_req       = r_pending;
   assign w_clr_s     = w_accept ? w_gvec : '0;
   assign w_ovr       = |(w_press & r_pending & ~w_clr_s);
   assign evt_long    = 1'b0;
`endif

   // Set wins over a same-cycle clear.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         r_pending     <= '0;
         r_evt_overrun <= 1'b0;
      end else begin
         r_pending     <= (r_pending & ~w_clr_s) | w_press;
         r_evt_overrun <= w_ovr;
      end
   end

   // First requester above last_grant, else first requester from index 0.
   always_comb begin
      w_found  = 1'b0;
      w_sel_id = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (!w_found && (i > int'(r_last_grant)) && w_req[i[IDX_W-1:0]]) begin
            w_found  = 1'b1;
            w_sel_id = ID_W'(i);
         end
      end
      for (int i = 0; i < NUM_BTN; i++) begin
         if (!w_found && w_req[i[IDX_W-1:0]]) begin
            w_found  = 1'b1;
            w_sel_id = ID_W'(i);
         end
      end
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         r_state      <= ST_IDLE;
         r_evt_valid  <= 1'b0;
         r_evt_id     <= '0;
         r_last_grant <= ID_W'(NUM_BTN - 1);
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_evt_id    <= w_sel_id;
                  r_evt_valid <= 1'b1;
                  r_state     <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (evt_ready) begin
                  r_last_grant <= r_evt_id;
                  r_evt_valid  <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_evt_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign evt_valid   = r_evt_valid;
   assign evt_id      = r_evt_id;
   assign evt_overrun = r_evt_overrun;
   assign pending     = r_pending;

endmodule

// File: tb/tb_btn_event_arb.sv
// Directed bench for btn_event_arb: scoreboard of expected events popped on each accepted handshake.
module tb_btn_event_arb;

   typedef struct {
      logic [1:0] id;
      logic       lng;
   } evt_t;

   logic       clock = 1'b0;
   logic       n_reset = 1'b0;
   logic [3:0] btn_in = 4'b0000;
   logic       evt_ready = 1'b0;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic       evt_long;
   logic       evt_overrun;
   logic [3:0] pending;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_ovr = 0;
   int   n_acc = 0;
   int   n_vcyc = 0;
   int   m_cnt;
   evt_t sb[$];

   btn_event_arb #(
      .NUM_BTN   (4),
      .ID_W      (2),
      .TICK_MAX  (20'd9),
      .LONG_TICKS(8'd3)
   ) dut (
      .clock      (clock),
      .n_reset    (n_reset),
      .btn_in     (btn_in),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_id     (evt_id),
      .evt_long   (evt_long),
      .evt_overrun(evt_overrun),
      .pending    (pending)
   );

   initial forever #5 clock = ~clock;

   // Independent tick model: a tick cycle is one where m_cnt == 9.
   always @(posedge clock or negedge n_reset) begin
      if (!n_reset) m_cnt <= 0;
      else          m_cnt <= (m_cnt == 9) ? 0 : m_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic evt_t mk(input logic [1:0] id, input logic lng);
      evt_t e;
      e.id  = id;
      e.lng = lng;
      return e;
   endfunction

   task automatic wait_tick();
      for (int i = 0; i < 25; i++) begin
         @(negedge clock);
         if (m_cnt == 9) return;
      end
      n_cmp++;
      n_bad++;
      $error("FAIL tick_timeout: observed no tick expected tick within 25 clocks");
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (sb.size() == 0) break;
      end
      chk("drain", sb.size(), 0);
   endtask

   // Raise mask just after a tick, let the next tick sample it, release hold clocks later.
   task automatic press(input logic [3:0] mask, input int hold);
      wait_tick();
      @(posedge clock); #1;
      btn_in = btn_in | mask;
      wait_tick();
      repeat (hold) @(posedge clock);
      #1;
      btn_in = btn_in & ~mask;
   endtask

   // Monitor: scoreboard pops, hold-stability while stalled, overrun and valid counters.
   initial begin : mon
      logic       hv;
      logic [1:0] hid;
      logic       hl;
      evt_t       e;
      hv  = 1'b0;
      hid = 2'd0;
      hl  = 1'b0;
      forever begin
         @(negedge clock);
         if (!n_reset) begin
            hv = 1'b0;
            continue;
         end
         if (evt_overrun) n_ovr++;
         if (evt_valid)   n_vcyc++;
         if (hv) begin
            chk("hold_valid", evt_valid, 1);
            chk("hold_id", evt_id, hid);
            chk("hold_long", evt_long, hl);
         end
         if (evt_valid && evt_ready) begin
            n_acc++;
            chk("sb_has_entry", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("evt_id", evt_id, e.id);
               chk("evt_long", evt_long, e.lng);
            end
         end
         hv  = evt_valid && !evt_ready;
         hid = evt_id;
         hl  = evt_long;
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: observed no finish expected finish before 30000 clocks");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int a0;
      int v0;
      int o0;

      // 1: reset values, then idle with no buttons
      repeat (3) @(negedge clock);
      chk("rst_valid", evt_valid, 0);
      chk("rst_pending", pending, 0);
      chk("rst_id", evt_id, 0);
      chk("rst_long", evt_long, 0);
      chk("rst_overrun", evt_overrun, 0);
      @(posedge clock); #1;
      n_reset   = 1'b1;
      evt_ready = 1'b1;
      v0 = n_vcyc;
      repeat (30) @(negedge clock);
      chk("idle_valid_cycles", n_vcyc - v0, 0);
      chk("idle_pending", pending, 0);

      // 2: btn 2, exact latency from the sampling tick
      a0 = n_acc;
      wait_tick();
      @(posedge clock); #1;
      btn_in[2] = 1'b1;
      sb.push_back(mk(2'd2, 1'b0));
      wait_tick();
      chk("t2_pend_at_tick", pending, 4'b0000);
      @(negedge clock);
      chk("t2_pend_tplus1", pending, 4'b0100);
      chk("t2_valid_tplus1", evt_valid, 0);
      @(negedge clock);
      chk("t2_valid_tplus2", evt_valid, 1);
      chk("t2_id_tplus2", evt_id, 2);
      @(negedge clock);
      chk("t2_valid_tplus3", evt_valid, 0);
      chk("t2_pend_tplus3", pending, 4'b0000);
      repeat (9) @(posedge clock);
      #1;
      btn_in[2] = 1'b0;
      repeat (40) @(negedge clock);
      wait_drain();
      chk("t2_event_count", n_acc - a0, 1);

      // 3: bouncing btn 3 settles high inside one tick window
      a0 = n_acc;
      wait_tick();
      for (int k = 0; k < 8; k++) begin
         @(posedge clock); #1;
         btn_in[3] = (((k / 3) % 2) == 0);
      end
      btn_in[3] = 1'b1;
      sb.push_back(mk(2'd3, 1'b0));
      wait_tick();
      repeat (12) @(posedge clock);
      #1;
      btn_in[3] = 1'b0;
      repeat (40) @(negedge clock);
      wait_drain();
      chk("t3_event_count", n_acc - a0, 1);

      // 4: simultaneous 0,1,3 with last grant 3 -> 0,1,3, twice
      for (int b = 0; b < 2; b++) begin
         a0 = n_acc;
         sb.push_back(mk(2'd0, 1'b0));
         sb.push_back(mk(2'd1, 1'b0));
         sb.push_back(mk(2'd3, 1'b0));
         press(4'b1011, 12);
         repeat (30) @(negedge clock);
         wait_drain();
         chk("t4_event_count", n_acc - a0, 3);
      end
      chk("no_overrun_so_far", n_ovr, 0);

      // 5: stalled consumer, second press merges and raises one overrun
      evt_ready = 1'b0;
      a0 = n_acc;
      o0 = n_ovr;
      wait_tick();
      @(posedge clock); #1;
      btn_in[1] = 1'b1;
      sb.push_back(mk(2'd1, 1'b0));
      wait_tick();
      repeat (3) @(posedge clock);
      #1;
      btn_in[1] = 1'b0;
      wait_tick();
      @(posedge clock); #1;
      btn_in[1] = 1'b1;
      wait_tick();
      repeat (5) @(posedge clock);
      #1;
      btn_in[1] = 1'b0;
      repeat (20) @(negedge clock);
      chk("t5_overrun_pulses", n_ovr - o0, 1);
      chk("t5_valid_held", evt_valid, 1);
      chk("t5_id_held", evt_id, 1);
      chk("t5_pending", pending, 4'b0010);
      @(posedge clock); #1;
      evt_ready = 1'b1;
      wait_drain();
      repeat (30) @(negedge clock);
      chk("t5_event_count", n_acc - a0, 1);
      chk("t5_pending_after", pending, 0);

      // 6: hold btn 3 for 5 ticks
      a0 = n_acc;
      o0 = n_ovr;
      sb.push_back(mk(2'd3, 1'b0));
`ifdef LONG_PRESS_EN
      sb.push_back(mk(2'd3, 1'b1));
`endif
      press(4'b1000, 45);
      repeat (40) @(negedge clock);
      wait_drain();
`ifdef LONG_PRESS_EN
      chk("t6_event_count", n_acc - a0, 2);
`else
      chk("t6_event_count", n_acc - a0, 1);
`endif
      chk("t6_overrun", n_ovr - o0, 0);
      chk("t6_pending", pending, 0);

      // Reset while an event is presented: dropped, not replayed
      evt_ready = 1'b0;
      press(4'b0001, 12);
      @(negedge clock);
      chk("rmid_valid_before", evt_valid, 1);
      chk("rmid_id_before", evt_id, 0);
      @(posedge clock); #1;
      n_reset = 1'b0;
      #1;
      chk("rmid_valid", evt_valid, 0);
      chk("rmid_pending", pending, 0);
      repeat (3) @(negedge clock);
      @(posedge clock); #1;
      n_reset   = 1'b1;
      evt_ready = 1'b1;
      a0 = n_acc;
      repeat (40) @(negedge clock);
      chk("rmid_no_replay", n_acc - a0, 0);
      chk("rmid_pending_after", pending, 0);
      chk("sb_empty_end", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
